ddr_frame_sched: RTL and testbench

//   Schedules 32000-byte frame transfers into and out of the PL DDR ring buffer.

---
 rtl/ddr_frame_sched.sv | 171 +++++++++++++++++
 tb/tb_ddr_frame_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : ddr_frame_sched
// Purpose  : Round-robin scheduler for frame writes/reads on a shared DDR port,
//            with ring-buffer pointers, fill count and a per-transfer watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_frame_sched #(
  parameter int unsigned FRAME_BYTES = 32000,
  parameter int unsigned RING_FRAMES = 6000,
  parameter logic [31:0] BASE_ADDR   = 32'd0,
  parameter int unsigned TIMEOUT_CYC = 2**20
) (
  input  logic        pl_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr_req,
  input  logic        rd_req,
  output logic        pl_ddr_wr_start,
  output logic [31:0] pl_ddr_wr_addr,
  output logic [31:0] pl_ddr_wr_length,
  input  logic        pl_ddr_wr_finish,
  output logic        pl_ddr_rd_start,
  output logic [31:0] pl_ddr_rd_addr,
  output logic [31:0] pl_ddr_rd_length,
  input  logic        pl_ddr_rd_finish,
  output logic [12:0] frame_count,
  output logic        ring_full,
  output logic        ring_empty,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [31:0] c_FRAME     = 32'(FRAME_BYTES);
  localparam logic [31:0] c_LAST_ADDR = BASE_ADDR + 32'((RING_FRAMES - 1) * FRAME_BYTES);
  localparam logic [12:0] c_RING      = 13'(RING_FRAMES);
  localparam int          c_WD_W      = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_GO   = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_GO   = 3'd3,
    S_RD_WAIT = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_last_wr;
  logic              r_wr_fin_d;
  logic              r_rd_fin_d;
  logic [c_WD_W-1:0] r_wd;
  logic [12:0]       r_count;
  logic [31:0]       r_wr_addr;
  logic [31:0]       r_rd_addr;
  logic              r_wr_start;
  logic              r_rd_start;
  logic [31:0]       r_len;
  logic              r_timeout;

  logic        w_wr_edge;
  logic        w_rd_edge;
  logic        w_full;
  logic        w_empty;
  logic        w_wr_ok;
  logic        w_rd_ok;
  logic        w_pick_wr;
  logic [31:0] w_wr_next;
  logic [31:0] w_rd_next;

  assign w_wr_edge = pl_ddr_wr_finish & ~r_wr_fin_d;
  assign w_rd_edge = pl_ddr_rd_finish & ~r_rd_fin_d;
  assign w_full    = (r_count == c_RING);
  assign w_empty   = (r_count == 13'd0);
  assign w_wr_ok   = enable & wr_req & ~w_full;
  assign w_rd_ok   = enable & rd_req & ~w_empty;
  // On a tie the side that did not win last time gets the port.
  assign w_pick_wr = w_wr_ok & (~w_rd_ok | ~r_last_wr);
  assign w_wr_next = (r_wr_addr == c_LAST_ADDR) ? BASE_ADDR : r_wr_addr + c_FRAME;
  assign w_rd_next = (r_rd_addr == c_LAST_ADDR) ? BASE_ADDR : r_rd_addr + c_FRAME;

  always_ff @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      r_wr_fin_d <= 1'b0;
      r_rd_fin_d <= 1'b0;
      r_len      <= 32'd0;
    end else begin
      r_wr_fin_d <= pl_ddr_wr_finish;
      r_rd_fin_d <= pl_ddr_rd_finish;
      r_len      <= c_FRAME;
    end
  end

  always_ff @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_last_wr  <= 1'b0;
      r_wd       <= '0;
      r_count    <= 13'd0;
      r_wr_addr  <= BASE_ADDR;
      r_rd_addr  <= BASE_ADDR;
      r_wr_start <= 1'b0;
      r_rd_start <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_wr_start <= 1'b0;
      r_rd_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_wr) begin
            r_state    <= S_WR_GO;
            r_wr_start <= 1'b1;
          end else if (w_rd_ok) begin
            r_state    <= S_RD_GO;
            r_rd_start <= 1'b1;
          end
        end
        // Finish edges coinciding with the start pulse are deliberately dropped.
        S_WR_GO: begin
          r_state <= S_WR_WAIT;
          r_wd    <= '0;
        end
        S_WR_WAIT: begin
          if (w_wr_edge) begin
            r_state   <= S_IDLE;
            r_count   <= r_count + 13'd1;
            r_wr_addr <= w_wr_next;
            r_last_wr <= 1'b1;
          end else if (r_wd == c_WD_LAST) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_RD_GO: begin
          r_state <= S_RD_WAIT;
          r_wd    <= '0;
        end
        S_RD_WAIT: begin
          if (w_rd_edge) begin
            r_state   <= S_IDLE;
            r_count   <= r_count - 13'd1;
            r_rd_addr <= w_rd_next;
            r_last_wr <= 1'b0;
          end else if (r_wd == c_WD_LAST) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pl_ddr_wr_start  = r_wr_start;
  assign pl_ddr_wr_addr   = r_wr_addr;
  assign pl_ddr_wr_length = r_len;
  assign pl_ddr_rd_start  = r_rd_start;
  assign pl_ddr_rd_addr   = r_rd_addr;
  assign pl_ddr_rd_length = r_len;
  assign frame_count      = r_count;
  assign ring_full        = w_full;
  assign ring_empty       = w_empty;
  assign busy             = (r_state != S_IDLE);
  assign timeout_err      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ddr_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_frame_sched
// Purpose  : Directed self-checking bench for ddr_frame_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_frame_sched;

  localparam logic [31:0] c_FRAME = 32'd32000;
  localparam logic [31:0] c_LAST  = 32'd191968000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
  logic        wr_fin = 1'b0, rd_fin = 1'b0;
  logic        wr_start, rd_start, ring_full, ring_empty, busy, timeout_err;
  logic [31:0] wr_addr, wr_len, rd_addr, rd_len;
  logic [12:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_count = 0;
  logic [31:0] exp_wr = 32'd0, exp_rd = 32'd0;

  always #5 clk = ~clk;

  ddr_frame_sched #(.TIMEOUT_CYC(64)) dut (
    .pl_clk(clk), .rst(rst_n), .enable(enable), .wr_req(wr_req), .rd_req(rd_req),
    .pl_ddr_wr_start(wr_start), .pl_ddr_wr_addr(wr_addr), .pl_ddr_wr_length(wr_len),
    .pl_ddr_wr_finish(wr_fin),
    .pl_ddr_rd_start(rd_start), .pl_ddr_rd_addr(rd_addr), .pl_ddr_rd_length(rd_len),
    .pl_ddr_rd_finish(rd_fin),
    .frame_count(frame_count), .ring_full(ring_full), .ring_empty(ring_empty),
    .busy(busy), .timeout_err(timeout_err)
  );

  function automatic logic [31:0] nxt(input logic [31:0] a);
    return (a == c_LAST) ? 32'd0 : a + c_FRAME;
  endfunction

  // side: 0 none, 1 write, 2 read, 3 both
  task automatic wait_start(input int max_cyc, output int side, output logic [31:0] addr,
                            output int cyc);
    side = 0; addr = 32'd0; cyc = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk); #1;
      if (wr_start || rd_start) begin
        side = (wr_start ? 1 : 0) + (rd_start ? 2 : 0);
        addr = wr_start ? wr_addr : rd_addr;
        cyc  = i;
        break;
      end
    end
  endtask

  task automatic pulse_fin(input int side, input int delay);
    repeat (delay) @(posedge clk);
    #1;
    if (side == 1) wr_fin = 1'b1; else rd_fin = 1'b1;
    @(posedge clk); #1;
    wr_fin = 1'b0; rd_fin = 1'b0;
  endtask

  task automatic model_done(input int side);
    if (side == 1) begin exp_count++; exp_wr = nxt(exp_wr); end
    else           begin exp_count--; exp_rd = nxt(exp_rd); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    n_cmp++; if ({wr_start, rd_start} !== 2'b00) begin n_bad++; $display("FAIL reset_start got %b want 00", {wr_start, rd_start}); end
    n_cmp++; if ({wr_addr, rd_addr} !== 64'd0) begin n_bad++; $display("FAIL reset_addr got %0d/%0d want 0/0", wr_addr, rd_addr); end
    n_cmp++; if ({wr_len, rd_len} !== 64'd0) begin n_bad++; $display("FAIL reset_len got %0d/%0d want 0/0", wr_len, rd_len); end
    n_cmp++; if (frame_count !== 13'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", frame_count); end
    n_cmp++; if ({busy, timeout_err, ring_full} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {busy, timeout_err, ring_full}); end
  endtask

  task automatic test_write();
    int side, cyc; logic [31:0] a;
    enable = 1'b1; wr_req = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_start(10, side, a, cyc);
      if (k == 0) begin
        n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL first_start_cycle got %0d want 1", cyc); end
        n_cmp++; if (wr_len !== c_FRAME || rd_len !== c_FRAME) begin n_bad++; $display("FAIL length got %0d/%0d want 32000", wr_len, rd_len); end
      end
      n_cmp++; if (side !== 1 || a !== exp_wr) begin n_bad++; $display("FAIL wr_start got side %0d addr %0d want 1 %0d", side, a, exp_wr); end
      pulse_fin(1, 10);
      if (k == 3) wr_req = 1'b0;
      model_done(1);
      n_cmp++; if (frame_count !== 13'(exp_count) || wr_addr !== exp_wr) begin n_bad++; $display("FAIL wr_done got %0d/%0d want %0d/%0d", frame_count, wr_addr, exp_count, exp_wr); end
    end
  endtask

  task automatic test_single_read();
    int side, cyc; logic [31:0] a;
    rd_req = 1'b1;
    wait_start(10, side, a, cyc);
    rd_req = 1'b0;
    n_cmp++; if (side !== 2 || a !== 32'd0) begin n_bad++; $display("FAIL rd_start got side %0d addr %0d want 2 0", side, a); end
    pulse_fin(2, 1);
    model_done(2);
    n_cmp++; if (frame_count !== 13'd3 || rd_addr !== 32'd32000) begin n_bad++; $display("FAIL rd_done got %0d/%0d want 3/32000", frame_count, rd_addr); end
  endtask

  task automatic test_round_robin();
    int side, cyc, want; logic [31:0] a;
    wr_req = 1'b1; rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      want = (k % 2 == 0) ? 1 : 2;
      wait_start(10, side, a, cyc);
      n_cmp++; if (side !== want || a !== (want == 1 ? exp_wr : exp_rd)) begin n_bad++; $display("FAIL rr_grant%0d got side %0d addr %0d want %0d", k, side, a, want); end
      pulse_fin(want, 1);
      if (k == 3) begin wr_req = 1'b0; rd_req = 1'b0; end
      model_done(want);
      n_cmp++; if (frame_count !== 13'((k % 2 == 0) ? 4 : 3)) begin n_bad++; $display("FAIL rr_count%0d got %0d want %0d", k, frame_count, (k % 2 == 0) ? 4 : 3); end
    end
  endtask

  task automatic test_full_and_wrap();
    int side, cyc; logic [31:0] a;
    wr_req = 1'b1;
    while (exp_count < 6000) begin
      wait_start(10, side, a, cyc);
      n_cmp++; if (side !== 1 || a !== exp_wr) begin n_bad++; $display("FAIL fill_start got side %0d addr %0d want 1 %0d", side, a, exp_wr); break; end
      pulse_fin(1, 1);
      model_done(1);
      if (a == c_LAST) begin
        n_cmp++; if (wr_addr !== 32'd0) begin n_bad++; $display("FAIL wr_wrap got %0d want 0", wr_addr); end
      end
    end
    n_cmp++; if (frame_count !== 13'd6000 || ring_full !== 1'b1) begin n_bad++; $display("FAIL full got %0d/%b want 6000/1", frame_count, ring_full); end
    wait_start(20, side, a, cyc);
    n_cmp++; if (side !== 0) begin n_bad++; $display("FAIL full_blocks_wr got side %0d want 0", side); end
    rd_req = 1'b1;
    wait_start(10, side, a, cyc);
    rd_req = 1'b0;
    n_cmp++; if (side !== 2 || a !== exp_rd) begin n_bad++; $display("FAIL full_read got side %0d addr %0d want 2 %0d", side, a, exp_rd); end
    pulse_fin(2, 1);
    model_done(2);
    wait_start(5, side, a, cyc);
    n_cmp++; if (side !== 1 || a !== exp_wr) begin n_bad++; $display("FAIL refill got side %0d addr %0d want 1 %0d", side, a, exp_wr); end
    pulse_fin(1, 1);
    wr_req = 1'b0;
    model_done(1);
    n_cmp++; if (frame_count !== 13'd6000) begin n_bad++; $display("FAIL refill_count got %0d want 6000", frame_count); end
  endtask

  task automatic test_drain_and_wrap();
    int side, cyc; logic [31:0] a;
    rd_req = 1'b1;
    while (exp_count > 0) begin
      wait_start(10, side, a, cyc);
      n_cmp++; if (side !== 2 || a !== exp_rd) begin n_bad++; $display("FAIL drain_start got side %0d addr %0d want 2 %0d", side, a, exp_rd); break; end
      pulse_fin(2, 1);
      model_done(2);
      if (a == c_LAST) begin
        n_cmp++; if (rd_addr !== 32'd0) begin n_bad++; $display("FAIL rd_wrap got %0d want 0", rd_addr); end
      end
    end
    n_cmp++; if (frame_count !== 13'd0 || ring_empty !== 1'b1) begin n_bad++; $display("FAIL empty got %0d/%b want 0/1", frame_count, ring_empty); end
    wait_start(20, side, a, cyc);
    rd_req = 1'b0;
    n_cmp++; if (side !== 0) begin n_bad++; $display("FAIL empty_blocks_rd got side %0d want 0", side); end
  endtask

  task automatic test_ignored_finish();
    int side, cyc; logic [31:0] a;
    wr_req = 1'b1;
    wait_start(10, side, a, cyc);
    n_cmp++; if (side !== 1 || a !== exp_wr) begin n_bad++; $display("FAIL ign_start got side %0d addr %0d want 1 %0d", side, a, exp_wr); end
    wr_fin = 1'b1;
    @(posedge clk); #1 wr_fin = 1'b0; rd_fin = 1'b1;
    @(posedge clk); #1 rd_fin = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b1 || frame_count !== 13'd0) begin n_bad++; $display("FAIL ign_fin got busy %b count %0d want 1 0", busy, frame_count); end
    n_cmp++; if (rd_addr !== exp_rd || wr_addr !== exp_wr) begin n_bad++; $display("FAIL ign_ptr got %0d/%0d want %0d/%0d", wr_addr, rd_addr, exp_wr, exp_rd); end
    pulse_fin(1, 0);
    wr_req = 1'b0;
    model_done(1);
    n_cmp++; if (frame_count !== 13'd1 || busy !== 1'b0) begin n_bad++; $display("FAIL ign_done got count %0d busy %b want 1 0", frame_count, busy); end
  endtask

  task automatic test_timeout();
    int side, cyc; logic [31:0] a;
    wr_req = 1'b1;
    wait_start(10, side, a, cyc);
    n_cmp++; if (side !== 1 || a !== exp_wr) begin n_bad++; $display("FAIL to_start got side %0d addr %0d want 1 %0d", side, a, exp_wr); end
    repeat (64) @(posedge clk); #1;
    n_cmp++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL to_early got err %b busy %b want 0 1", timeout_err, busy); end
    @(posedge clk); #1;
    n_cmp++; if (timeout_err !== 1'b1 || busy !== 1'b0 || frame_count !== 13'd1) begin n_bad++; $display("FAIL to_fire got err %b busy %b count %0d want 1 0 1", timeout_err, busy, frame_count); end
    wait_start(5, side, a, cyc);
    n_cmp++; if (side !== 1 || a !== exp_wr || cyc !== 1) begin n_bad++; $display("FAIL to_retry got side %0d addr %0d cyc %0d want 1 %0d 1", side, a, cyc, exp_wr); end
    pulse_fin(1, 1);
    wr_req = 1'b0;
    model_done(1);
    n_cmp++; if (frame_count !== 13'd2 || timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky got count %0d err %b want 2 1", frame_count, timeout_err); end
  endtask

  task automatic test_enable_drop();
    int side, cyc; logic [31:0] a;
    wr_req = 1'b1;
    wait_start(10, side, a, cyc);
    enable = 1'b0;
    n_cmp++; if (side !== 1 || a !== exp_wr) begin n_bad++; $display("FAIL en_start got side %0d addr %0d want 1 %0d", side, a, exp_wr); end
    pulse_fin(1, 1);
    model_done(1);
    n_cmp++; if (frame_count !== 13'd3 || wr_addr !== exp_wr) begin n_bad++; $display("FAIL en_done got %0d/%0d want 3/%0d", frame_count, wr_addr, exp_wr); end
    wait_start(10, side, a, cyc);
    n_cmp++; if (side !== 0 || busy !== 1'b0) begin n_bad++; $display("FAIL en_nogrant got side %0d busy %b want 0 0", side, busy); end
    wr_req = 1'b0; enable = 1'b1;
  endtask

  task automatic test_reset_mid_transfer();
    int side, cyc; logic [31:0] a;
    wr_req = 1'b1;
    wait_start(10, side, a, cyc);
    @(posedge clk); #1;
    rst_n = 1'b0; wr_fin = 1'b1; wr_req = 1'b0;
    #1;
    n_cmp++; if ({wr_start, busy, timeout_err} !== 3'b000 || frame_count !== 13'd0) begin n_bad++; $display("FAIL rst_mid got st/busy/err %b count %0d want 000 0", {wr_start, busy, timeout_err}, frame_count); end
    n_cmp++; if (wr_addr !== 32'd0 || rd_addr !== 32'd0 || wr_len !== 32'd0) begin n_bad++; $display("FAIL rst_mid_addr got %0d/%0d/%0d want 0/0/0", wr_addr, rd_addr, wr_len); end
    exp_count = 0; exp_wr = 32'd0; exp_rd = 32'd0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1; wr_req = 1'b1;
    wait_start(5, side, a, cyc);
    n_cmp++; if (side !== 1 || a !== 32'd0) begin n_bad++; $display("FAIL rst_regrant got side %0d addr %0d want 1 0", side, a); end
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b1 || frame_count !== 13'd0) begin n_bad++; $display("FAIL held_fin got busy %b count %0d want 1 0", busy, frame_count); end
    wr_fin = 1'b0;
    @(posedge clk);
    pulse_fin(1, 0);
    wr_req = 1'b0;
    model_done(1);
    n_cmp++; if (frame_count !== 13'd1 || wr_addr !== 32'd32000) begin n_bad++; $display("FAIL rst_done got %0d/%0d want 1/32000", frame_count, wr_addr); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_single_read();
    test_round_robin();
    test_full_and_wrap();
    test_drain_and_wrap();
    test_ignored_finish();
    test_timeout();
    test_enable_drop();
    test_reset_mid_transfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
